// File: rtl/rv32i_dmem_ctrl.sv
// rv32i_dmem_ctrl: word-organised data RAM behind a req/ready handshake with LATENCY wait states.
module rv32i_dmem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req,
    input  logic        d_wr_en,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [2:0]  d_func3,
    output logic        d_ready,
    output logic [31:0] dRdata,
    output logic        d_err,
    output logic [31:0] tb_ram_data,
    output logic        tb_busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       ram_q [2**ADDR_W];
    logic              accept, enter_done, err, illegal, misal;
    logic [31:0]       word, ld, wlane;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [3:0]        wmask;
    logic              unused_addr;
    assign unused_addr = ^dAddr[31:ADDR_W+2];
    // With LATENCY=0 the access completes on the accepting edge, so it must see the live inputs.
    always_comb begin
        accept     = state_q == IDLE && d_req;
        enter_done = (accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd1);
        addr_d     = accept ? dAddr[ADDR_W+1:0] : addr_q;
        wdata_d    = accept ? dWdata : wdata_q;
        func3_d    = accept ? d_func3 : func3_q;
        we_d       = accept ? d_wr_en : we_q;
        word       = ram_q[addr_d[ADDR_W+1:2]];
        lane_b     = word[{addr_d[1:0], 3'b000} +: 8];
        lane_h     = word[{addr_d[1], 4'b0000} +: 16];
        ld         = func3_d[1] ? word :
                     func3_d[0] ? {{16{~func3_d[2] & lane_h[15]}}, lane_h} :
                                  {{24{~func3_d[2] & lane_b[7]}}, lane_b};
        illegal    = we_d ? func3_d > 3'd2 : (func3_d[1:0] == 2'b11 || func3_d == 3'b110);
        misal      = (func3_d[1:0] == 2'b01 && addr_d[0]) || (func3_d[1:0] == 2'b10 && |addr_d[1:0]);
        err        = illegal || misal;
        wmask      = func3_d[1] ? 4'b1111 :
                     func3_d[0] ? 4'b0011 << {addr_d[1], 1'b0} : 4'b0001 << addr_d[1:0];
        wlane      = func3_d[1] ? wdata_d : func3_d[0] ? {2{wdata_d[15:0]}} : {4{wdata_d[7:0]}};
        state_d    = enter_done ? DONE : accept ? WAIT : (state_q == DONE ? IDLE : state_q);
        cnt_d      = accept ? 4'(LATENCY) : (state_q == WAIT ? cnt_q - 4'd1 : cnt_q);
        rdata_d    = enter_done ? ((we_d || err) ? 32'h0 : ld) : rdata_q;
        err_d      = enter_done ? err : err_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        func3_q <= func3_d;
        we_q    <= we_d;
    end
    always_ff @(posedge clk) begin
        if (!reset && enter_done && we_d && !err)
            for (int b = 0; b < 4; b++)
                if (wmask[b]) ram_q[addr_d[ADDR_W+1:2]][8*b +: 8] <= wlane[8*b +: 8];
    end
    assign d_ready     = state_q == DONE;
    assign dRdata      = rdata_q;
    assign d_err       = err_q;
    assign tb_ram_data = ram_q[addr_q[ADDR_W+1:2]];
    assign tb_busy     = state_q != IDLE;
endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// tb_rv32i_dmem_ctrl: directed and random accesses against a byte-level memory model, LATENCY=2 and LATENCY=0.
module tb_rv32i_dmem_ctrl;
    logic        clk = 0, reset = 1, req_a = 0, req_b = 0, d_wr_en = 0;
    logic [31:0] dAddr = 0, dWdata = 0;
    logic [2:0]  d_func3 = 0;
    logic        rdy_a, err_a, busy_a, rdy_b, err_b, busy_b;
    logic [31:0] rd_a, trace_a, rd_b, trace_b;
    logic [31:0] mem_m [2][1024];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    rv32i_dmem_ctrl u_a (.clk(clk), .reset(reset), .d_req(req_a), .d_wr_en(d_wr_en), .dAddr(dAddr),
        .dWdata(dWdata), .d_func3(d_func3), .d_ready(rdy_a), .dRdata(rd_a), .d_err(err_a),
        .tb_ram_data(trace_a), .tb_busy(busy_a));
    rv32i_dmem_ctrl #(.LATENCY(0)) u_b (.clk(clk), .reset(reset), .d_req(req_b), .d_wr_en(d_wr_en),
        .dAddr(dAddr), .dWdata(dWdata), .d_func3(d_func3), .d_ready(rdy_b), .dRdata(rd_b), .d_err(err_b),
        .tb_ram_data(trace_b), .tb_busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {err, rdata} and applies the store to the model, straight from the RV32I rules.
    function automatic logic [32:0] model(input bit f, input bit we, input logic [31:0] addr, wd,
                                          input logic [2:0] f3);
        int off, idx, size;
        logic [63:0] m, v;
        bit legal;
        off   = int'(addr % 4);
        idx   = int'((addr / 4) % 1024);
        size  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        legal = we ? f3 <= 3'd2 : (f3 != 3'd3 && f3 < 3'd6);
        if (!legal || off % size != 0) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < size; i++) mem_m[f][idx][8*(off+i) +: 8] = wd[8*i +: 8];
            return 33'h0;
        end
        m = (64'd1 << (8 * size)) - 64'd1;
        v = ({32'h0, mem_m[f][idx]} >> (8 * off)) & m;
        if (!f3[2] && v[8*size-1]) v = v | ~m;
        return {1'b0, v[31:0]};
    endfunction

    task automatic op(input bit f, input bit we, input logic [31:0] addr, wd, input logic [2:0] f3,
                      input bit hold, output logic [31:0] rd, output logic er);
        logic [32:0] e;
        int lat;
        int idx;
        idx = int'((addr / 4) % 1024);
        e = model(f, we, addr, wd, f3);
        @(negedge clk);
        d_wr_en = we; dAddr = addr; dWdata = wd; d_func3 = f3;
        if (f) req_b = 1; else req_a = 1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(f ? rdy_b : rdy_a) && lat < 40);
        rd = f ? rd_b : rd_a;
        er = f ? err_b : err_a;
        if (!hold) begin req_a = 0; req_b = 0; end
        chk("latency", lat, f ? 1 : 3);
        chk("rdata", rd, e[31:0]);
        chk("err", {31'h0, er}, {31'h0, e[32]});
        if (!$isunknown(mem_m[f][idx])) chk("trace", f ? trace_b : trace_a, mem_m[f][idx]);
        @(negedge clk);
        chk("pulse", {30'h0, f ? rdy_b : rdy_a, f ? busy_b : busy_a}, 32'h0);
        req_a = 0; req_b = 0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int f = 0; f < 2; f++) for (int i = 0; i < 1024; i++) mem_m[f][i] = 'x;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        chk("rst_ready", {31'h0, rdy_a}, 0);
        chk("rst_err", {31'h0, err_a}, 0);
        chk("rst_rdata", rd_a, 0);
        chk("rst_busy", {31'h0, busy_a}, 0);
        // Word access, byte and half merge
        op(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er);
        chk("sw_err", {31'h0, er}, 0);
        op(0, 0, 32'h10, 0, 3'b010, 0, rd, er);  chk("lw1", rd, 32'hDEADBEEF);
        op(0, 1, 32'h13, 32'hAA, 3'b000, 0, rd, er);
        op(0, 0, 32'h10, 0, 3'b010, 0, rd, er);  chk("lw2", rd, 32'hAAADBEEF);
        op(0, 0, 32'h13, 0, 3'b000, 0, rd, er);  chk("lb", rd, 32'hFFFFFFAA);
        op(0, 0, 32'h13, 0, 3'b100, 0, rd, er);  chk("lbu", rd, 32'h000000AA);
        op(0, 1, 32'h12, 32'h1234, 3'b001, 0, rd, er);
        op(0, 0, 32'h10, 0, 3'b010, 0, rd, er);  chk("lw3", rd, 32'h1234BEEF);
        op(0, 0, 32'h12, 0, 3'b001, 0, rd, er);  chk("lh_hi", rd, 32'h00001234);
        op(0, 0, 32'h10, 0, 3'b001, 0, rd, er);  chk("lh_lo", rd, 32'hFFFFBEEF);
        // Errors
        op(0, 0, 32'h11, 0, 3'b010, 0, rd, er);  chk("lw_mis_err", {31'h0, er}, 1); chk("lw_mis_rd", rd, 0);
        op(0, 1, 32'h12, 32'h0BADF00D, 3'b010, 0, rd, er);  chk("sw_mis_err", {31'h0, er}, 1);
        op(0, 0, 32'h10, 0, 3'b010, 0, rd, er);  chk("sw_mis_nowr", rd, 32'h1234BEEF);
        op(0, 0, 32'h10, 0, 3'b011, 0, rd, er);  chk("f3_011_err", {31'h0, er}, 1);
        // Reset during WAIT abandons the store
        op(0, 1, 32'h20, 32'hCAFEF00D, 3'b010, 0, rd, er);
        @(negedge clk);
        d_wr_en = 1; dAddr = 32'h20; dWdata = 32'h55; d_func3 = 3'b010; req_a = 1;
        @(negedge clk);
        chk("busy_wait", {31'h0, busy_a}, 1);
        reset = 1; req_a = 0;
        @(negedge clk);
        reset = 0;
        chk("rst_mid_ready", {31'h0, rdy_a}, 0);
        chk("rst_mid_busy", {31'h0, busy_a}, 0);
        repeat (3) begin @(negedge clk); chk("rst_mid_nopulse", {31'h0, rdy_a}, 0); end
        op(0, 0, 32'h20, 0, 3'b010, 0, rd, er);  chk("rst_mid_old", rd, 32'hCAFEF00D);
        // LATENCY=0: held request yields a single response; upper address bits alias
        op(1, 1, 32'h1010, 32'h1, 3'b010, 1, rd, er);
        op(1, 0, 32'h10, 0, 3'b010, 1, rd, er);  chk("alias", rd, 32'h1);
        // Random traffic over a pre-initialised window
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) op(f[0], 1, 32'h100 + 32'(4 * i), $urandom, 3'b010, 0, rd, er);
        for (int n = 0; n < 80; n++)
            op(n[0], $urandom_range(0, 1) == 1, 32'h100 + $urandom_range(0, 63), $urandom,
               3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, rd, er);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
